// File: rtl/core_pkg.sv
// ============================================================================
// Module      : core_pkg
// Description : Shared encodings, ALU operations and FSM states for core_mc.
// Revision    : 1.0 - initial multi-cycle release
// ============================================================================
`default_nettype none

package core_pkg;

  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_I      = 7'h13;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;

  localparam logic [2:0] F3_ADD = 3'd0;
  localparam logic [2:0] F3_SLL = 3'd1;
  localparam logic [2:0] F3_SLT = 3'd2;
  localparam logic [2:0] F3_XOR = 3'd4;
  localparam logic [2:0] F3_SRL = 3'd5;
  localparam logic [2:0] F3_OR  = 3'd6;
  localparam logic [2:0] F3_AND = 3'd7;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_SW  = 3'd2;
  localparam logic [2:0] F3_BEQ = 3'd0;
  localparam logic [2:0] F3_BNE = 3'd1;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6,
    ALU_SLT = 4'd7,
    ALU_LUI = 4'd8
  } alu_op_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    MEM   = 2'd2,
    HALT  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/core_mc_regfile.sv
// ============================================================================
// Module      : core_mc_regfile
// Description : 2R/1W register file, async clear, x0 hardwired to zero.
// Revision    : 1.0 - initial multi-cycle release
// ============================================================================
`default_nettype none

module core_mc_regfile #(
  parameter int NREGS = 32,
  parameter int XLEN  = 32,
  localparam int RW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [RW-1:0]   ra1,
  input  logic [RW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [RW-1:0]   wa,
  input  logic [XLEN-1:0] wd
);

  logic [XLEN-1:0] r_regs [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (we && (wa != '0)) begin
      r_regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == '0) ? '0 : r_regs[ra1];
  assign rd2 = (ra2 == '0) ? '0 : r_regs[ra2];

endmodule

`default_nettype wire

// File: rtl/core_mc.sv
// ============================================================================
// Module      : core_mc
// Description : Multi-cycle RV32I-subset core with req/ack imem/dmem ports.
// Revision    : 1.0 - initial multi-cycle release
// ============================================================================
`default_nettype none

module core_mc
  import core_pkg::*;
#(
  parameter int            XLEN     = 32,
  parameter int            AW       = 32,
  parameter int            NREGS    = 32,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   last_pc,
  output logic            imem_req,
  output logic [AW-1:0]   imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [AW-1:0]   dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            halted,
  output logic            illegal,
  output logic [XLEN-1:0] retired
);

  localparam int RW  = $clog2(NREGS);
  localparam int SHW = $clog2(XLEN);

  state_t          r_state, w_state_next;
  logic [AW-1:0]   r_pc;
  logic [31:0]     r_ir;
  logic [AW-1:0]   r_dmem_addr;
  logic [XLEN-1:0] r_dmem_wdata;
  logic            r_dmem_we;
  logic            r_illegal;
  logic [XLEN-1:0] r_retired;

  logic [6:0]      w_op, w_f7;
  logic [2:0]      w_f3;
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_u, w_rs1d, w_rs2d, w_b, w_alu, w_ea, w_rf_wd;
  logic [AW-1:0]   w_boff, w_pc_seq, w_pc_next;
  alu_op_t         w_alu_op;
  logic            w_use_imm, w_wb, w_mem, w_store, w_branch, w_bad;
  logic            w_taken, w_at_last, w_halt_exec, w_rf_we;

  assign w_op = r_ir[6:0];
  assign w_f3 = r_ir[14:12];
  assign w_f7 = r_ir[31:25];

  assign w_imm_i = XLEN'($signed(r_ir[31:20]));
  assign w_imm_s = XLEN'($signed({r_ir[31:25], r_ir[11:7]}));
  assign w_imm_u = XLEN'($signed({r_ir[31:12], 12'b0}));
  // B-format imm[12:1] field is taken directly as a signed word offset.
  assign w_boff  = AW'($signed({r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8]}));

  core_mc_regfile #(.NREGS(NREGS), .XLEN(XLEN)) u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (r_ir[15 +: RW]),
    .ra2   (r_ir[20 +: RW]),
    .rd1   (w_rs1d),
    .rd2   (w_rs2d),
    .we    (w_rf_we),
    .wa    (r_ir[7 +: RW]),
    .wd    (w_rf_wd)
  );

  always_comb begin
    w_alu_op  = ALU_ADD;
    w_use_imm = 1'b0;
    w_wb      = 1'b0;
    w_mem     = 1'b0;
    w_store   = 1'b0;
    w_branch  = 1'b0;
    w_bad     = 1'b0;
    case (w_op)
      OP_R: begin
        w_wb = 1'b1;
        w_bad = (w_f7 != F7_BASE) && !((w_f3 == F3_ADD) && (w_f7 == F7_ALT));
        case (w_f3)
          F3_ADD:  w_alu_op = (w_f7 == F7_ALT) ? ALU_SUB : ALU_ADD;
          F3_SLL:  w_alu_op = ALU_SLL;
          F3_SLT:  w_alu_op = ALU_SLT;
          F3_XOR:  w_alu_op = ALU_XOR;
          F3_SRL:  w_alu_op = ALU_SRL;
          F3_OR:   w_alu_op = ALU_OR;
          F3_AND:  w_alu_op = ALU_AND;
          default: w_bad    = 1'b1;
        endcase
      end
      OP_I: begin
        w_wb      = 1'b1;
        w_use_imm = 1'b1;
        case (w_f3)
          F3_ADD:  w_alu_op = ALU_ADD;
          F3_SLT:  w_alu_op = ALU_SLT;
          F3_XOR:  w_alu_op = ALU_XOR;
          F3_OR:   w_alu_op = ALU_OR;
          F3_AND:  w_alu_op = ALU_AND;
          default: w_bad    = 1'b1;
        endcase
      end
      OP_LUI: begin
        w_wb     = 1'b1;
        w_alu_op = ALU_LUI;
      end
      OP_LOAD: begin
        w_mem = 1'b1;
        w_bad = (w_f3 != F3_LW);
      end
      OP_STORE: begin
        w_mem   = 1'b1;
        w_store = 1'b1;
        w_bad   = (w_f3 != F3_SW);
      end
      OP_BRANCH: begin
        w_branch = 1'b1;
        w_bad    = (w_f3 != F3_BEQ) && (w_f3 != F3_BNE);
      end
      default: w_bad = 1'b1;
    endcase
    if (w_bad) begin
      w_wb     = 1'b0;
      w_mem    = 1'b0;
      w_store  = 1'b0;
      w_branch = 1'b0;
    end
  end

  assign w_b = w_use_imm ? w_imm_i : w_rs2d;

  always_comb begin
    case (w_alu_op)
      ALU_ADD: w_alu = w_rs1d + w_b;
      ALU_SUB: w_alu = w_rs1d - w_b;
      ALU_AND: w_alu = w_rs1d & w_b;
      ALU_OR:  w_alu = w_rs1d | w_b;
      ALU_XOR: w_alu = w_rs1d ^ w_b;
      ALU_SLL: w_alu = w_rs1d << w_b[SHW-1:0];
      ALU_SRL: w_alu = w_rs1d >> w_b[SHW-1:0];
      ALU_SLT: w_alu = {{(XLEN-1){1'b0}}, ($signed(w_rs1d) < $signed(w_b))};
      ALU_LUI: w_alu = w_imm_u;
      default: w_alu = '0;
    endcase
  end

  assign w_taken   = w_branch && ((w_f3 == F3_BNE) ? (w_rs1d != w_rs2d) : (w_rs1d == w_rs2d));
  assign w_pc_seq  = r_pc + AW'(1);
  assign w_pc_next = w_taken ? (r_pc + w_boff) : w_pc_seq;
  assign w_at_last = (r_pc == last_pc);
  // A taken branch at last_pc keeps running; only falling through ends the program.
  assign w_halt_exec = w_at_last && !w_taken;
  assign w_ea      = w_rs1d + (w_store ? w_imm_s : w_imm_i);

  assign w_rf_we = ((r_state == EXEC) && w_wb) || ((r_state == MEM) && dmem_ack && !r_dmem_we);
  assign w_rf_wd = (r_state == MEM) ? dmem_rdata : w_alu;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FETCH;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FETCH:   if (imem_ack) w_state_next = EXEC;
      EXEC:    w_state_next = w_mem ? MEM : (w_halt_exec ? HALT : FETCH);
      MEM:     if (dmem_ack) w_state_next = w_at_last ? HALT : FETCH;
      HALT:    w_state_next = HALT;
      default: w_state_next = FETCH;
    endcase
  end

  always_comb begin
    imem_req   = rst_n && (r_state == FETCH);
    imem_addr  = rst_n ? r_pc : '0;
    dmem_req   = (r_state == MEM);
    dmem_we    = (r_state == MEM) && r_dmem_we;
    dmem_addr  = r_dmem_addr;
    dmem_wdata = r_dmem_wdata;
    halted     = (r_state == HALT);
    illegal    = r_illegal;
    retired    = r_retired;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc         <= RESET_PC;
      r_ir         <= '0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
      r_dmem_we    <= 1'b0;
      r_illegal    <= 1'b0;
      r_retired    <= '0;
    end else begin
      case (r_state)
        FETCH: if (imem_ack) r_ir <= imem_rdata;
        EXEC: begin
          if (w_bad) r_illegal <= 1'b1;
          if (w_mem) begin
            r_dmem_addr  <= AW'(w_ea);
            r_dmem_wdata <= w_rs2d;
            r_dmem_we    <= w_store;
          end else begin
            r_retired <= r_retired + XLEN'(1);
            if (!w_halt_exec) r_pc <= w_pc_next;
          end
        end
        MEM: if (dmem_ack) begin
          r_retired <= r_retired + XLEN'(1);
          if (!w_at_last) r_pc <= w_pc_seq;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_core_mc.sv
// ============================================================================
// Module      : tb_core_mc
// Description : Directed self-checking bench for core_mc.
// Revision    : 1.0 - initial multi-cycle release
// ============================================================================
`default_nettype none

module tb_core_mc;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] last_pc;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        halted, illegal;
  logic [31:0] retired;

  logic [31:0] rom  [16];
  logic [31:0] dram [16];
  int          dlat;
  int          dcnt;
  bit          rnd;
  int          nerr;
  int          nchk;
  logic [31:0] save_pc, save_ret;

  always #5 clk = ~clk;

  core_mc dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .last_pc    (last_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .halted     (halted),
    .illegal    (illegal),
    .retired    (retired)
  );

  assign imem_rdata = rom[imem_addr[3:0]];
  assign dmem_rdata = dram[dmem_addr[3:0]];

  // Memory responder: zero-wait imem, dmem acks on the dlat-th request cycle.
  always @(negedge clk) begin
    if (rnd) begin
      imem_ack = ($urandom_range(0, 1) == 1);
      dmem_ack = ($urandom_range(0, 1) == 1);
      dcnt     = 0;
    end else begin
      imem_ack = 1'b1;
      if (dmem_req) begin
        if (dcnt == dlat - 1) begin
          dmem_ack = 1'b1;
          if (dmem_we) dram[dmem_addr[3:0]] = dmem_wdata;
        end else begin
          dmem_ack = 1'b0;
        end
        dcnt++;
      end else begin
        dmem_ack = 1'b0;
        dcnt     = 0;
      end
    end
  end

  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3, logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'h13};
  endfunction

  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_lw(logic [11:0] imm, logic [4:0] rs1, logic [4:0] rd);
    return {imm, rs1, 3'd2, rd, 7'h03};
  endfunction

  function automatic logic [31:0] enc_sw(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'd2, imm[4:0], 7'h23};
  endfunction

  // Word offset goes into the imm[12:1] field of the standard B layout.
  function automatic logic [31:0] enc_b(logic [11:0] off, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3);
    logic [12:0] b;
    b = {off, 1'b0};
    return {b[12], b[10:5], rs2, rs1, f3, b[4:1], b[11], 7'h63};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) begin
      rom[i]  = 32'h0;
      dram[i] = 32'h0;
    end
  endtask

  task automatic start();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_halt(input int maxc);
    int n;
    n = 0;
    while (halted !== 1'b1 && n < maxc) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("halt_reached", 32'(halted), 32'd1);
  endtask

  task automatic wait_dreq(input int maxc);
    int n;
    n = 0;
    while (dmem_req !== 1'b1 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk("dreq_seen", 32'(dmem_req), 32'd1);
  endtask

  initial begin
    nerr = 0; nchk = 0; rnd = 1'b0; dlat = 1;
    rst_n = 1'b0;
    clear_mem();

    // Reset state and first fetch; ALU chain
    rom[0] = enc_i(12'd5, 5'd0, 3'd0, 5'd1);
    rom[1] = enc_i(12'hFFD, 5'd0, 3'd0, 5'd2);
    rom[2] = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3);
    rom[3] = enc_r(7'h20, 5'd1, 5'd2, 3'd0, 5'd4);
    rom[4] = enc_sw(12'd4, 5'd3, 5'd0);
    rom[5] = enc_lw(12'd4, 5'd0, 5'd5);
    last_pc = 32'd3;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_imem_req",  32'(imem_req), 32'd0);
    chk("rst_dmem_req",  32'(dmem_req), 32'd0);
    chk("rst_dmem_we",   32'(dmem_we),  32'd0);
    chk("rst_halted",    32'(halted),   32'd0);
    chk("rst_illegal",   32'(illegal),  32'd0);
    chk("rst_retired",   retired,       32'd0);
    chk("rst_dmem_addr", dmem_addr,     32'd0);
    chk("rst_wdata",     dmem_wdata,    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("first_imem_req",  32'(imem_req), 32'd1);
    chk("first_imem_addr", imem_addr,     32'd0);
    repeat (7) begin @(posedge clk); #1; end
    chk("alu_not_halted_c7", 32'(halted), 32'd0);
    @(posedge clk); #1;
    chk("alu_halted_c8", 32'(halted), 32'd1);
    chk("alu_x3", dut.u_regfile.r_regs[3], 32'd2);
    chk("alu_x4", dut.u_regfile.r_regs[4], 32'hFFFF_FFF8);
    chk("alu_retired", retired, 32'd4);
    chk("alu_pc", dut.r_pc, 32'd3);

    // Load/store with 3-cycle dmem latency
    last_pc = 32'd5;
    dlat = 3;
    start();
    #1;
    chk("ls_retired_reset", retired, 32'd0);
    wait_dreq(40);
    for (int k = 0; k < 3; k++) begin
      chk("sw_req",   32'(dmem_req), 32'd1);
      chk("sw_we",    32'(dmem_we),  32'd1);
      chk("sw_addr",  dmem_addr,     32'd4);
      chk("sw_wdata", dmem_wdata,    32'd2);
      @(negedge clk);
    end
    chk("sw_req_drop", 32'(dmem_req), 32'd0);
    wait_halt(40);
    chk("ls_x5", dut.u_regfile.r_regs[5], 32'd2);
    chk("ls_mem4", dram[4], 32'd2);
    chk("ls_retired", retired, 32'd6);

    // Branch loop
    clear_mem();
    dlat = 1;
    rom[0] = enc_i(12'd3, 5'd0, 3'd0, 5'd1);
    rom[1] = enc_i(12'hFFF, 5'd1, 3'd0, 5'd1);
    rom[2] = enc_b(12'hFFF, 5'd0, 5'd1, 3'd1);
    last_pc = 32'd2;
    start();
    wait_halt(60);
    chk("br_x1", dut.u_regfile.r_regs[1], 32'd0);
    chk("br_retired", retired, 32'd7);
    chk("br_pc", dut.r_pc, 32'd2);

    // Halt hold under random acks
    save_pc  = dut.r_pc;
    save_ret = retired;
    rnd = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      chk("hold_imem_req", 32'(imem_req), 32'd0);
      chk("hold_dmem_req", 32'(dmem_req), 32'd0);
      chk("hold_halted",   32'(halted),   32'd1);
      chk("hold_pc",       dut.r_pc,      save_pc);
      chk("hold_retired",  retired,       save_ret);
    end
    rnd = 1'b0;

    // x0 write discard and illegal opcode
    clear_mem();
    rom[0] = enc_i(12'd7, 5'd0, 3'd0, 5'd0);
    rom[1] = 32'h0000_007F;
    rom[2] = enc_i(12'd1, 5'd0, 3'd0, 5'd6);
    last_pc = 32'd2;
    start();
    #1;
    chk("cc_illegal_clear", 32'(illegal), 32'd0);
    repeat (4) begin @(posedge clk); #1; end
    chk("cc_illegal_set", 32'(illegal), 32'd1);
    chk("cc_pc_after_illegal", dut.r_pc, 32'd2);
    wait_halt(40);
    chk("cc_x0", dut.u_regfile.r_regs[0], 32'd0);
    chk("cc_x6", dut.u_regfile.r_regs[6], 32'd1);
    chk("cc_retired", retired, 32'd3);

    // Reset asserted mid-MEM wait
    clear_mem();
    rom[0] = enc_sw(12'd0, 5'd0, 5'd0);
    last_pc = 32'd0;
    dlat = 10;
    start();
    wait_dreq(20);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mrst_dmem_req", 32'(dmem_req), 32'd0);
    chk("mrst_imem_req", 32'(imem_req), 32'd0);
    chk("mrst_state", 32'(dut.r_state), 32'(FETCH));
    chk("mrst_pc", dut.r_pc, 32'd0);
    chk("mrst_retired", retired, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mrst_refetch", 32'(imem_req), 32'd1);
    chk("mrst_refetch_addr", imem_addr, 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

`default_nettype wire
